// File: rtl/cache_pkg.sv
// Shared state encoding and default geometry for the direct-mapped cache controller.
package cache_pkg;

    localparam int unsigned DEF_TAG_WIDTH    = 26;
    localparam int unsigned DEF_SET_WIDTH    = 2;
    localparam int unsigned DEF_OFFSET_WIDTH = 4;
    localparam int unsigned ADDR_WIDTH       = 32;
    localparam int unsigned DATA_WIDTH       = 32;
    localparam int unsigned CNT_WIDTH        = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_REFILL    = 2'd3
    } cache_state_t;

endpackage

// File: rtl/cache_perf_cnt.sv
// Free-running hit/miss counters; wrap naturally at 2^CNT_WIDTH.
module cache_perf_cnt
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 hit_inc,
    input  logic                 miss_inc,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc)  hit_cnt  <= hit_cnt + CNT_WIDTH'(1);
            if (miss_inc) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller driving an external line store and word-wide memory.
// Optional performance counters are built only when CACHE_PERF_CNT_EN is defined.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int unsigned SET_WIDTH    = DEF_SET_WIDTH,
    parameter int unsigned OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cpu_req,
    input  logic                    cpu_wr,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic                    cpu_ready,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic [SET_WIDTH-1:0]    ln_sel,
    output logic [OFFSET_WIDTH-3:0] ln_offset,
    output logic                    ln_w_en,
    output logic                    ln_set_valid,
    output logic                    ln_set_dirty,
    output logic [TAG_WIDTH-1:0]    ln_set_tag,
    output logic [DATA_WIDTH-1:0]   ln_wdata,
    input  logic                    ln_valid,
    input  logic                    ln_dirty,
    input  logic [TAG_WIDTH-1:0]    ln_tag,
    input  logic [DATA_WIDTH-1:0]   ln_rdata,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [CNT_WIDTH-1:0]    hit_cnt,
    output logic [CNT_WIDTH-1:0]    miss_cnt
);

    localparam int unsigned WORD_W = OFFSET_WIDTH - 2;
    localparam logic [WORD_W-1:0] LAST_WORD = '1;

    cache_state_t            state_q, state_d;
    logic [WORD_W-1:0]       word_cnt_q, cnt_d;
    logic                    req_wr_q;
    logic [TAG_WIDTH-1:0]    req_tag_q;
    logic [SET_WIDTH-1:0]    req_set_q;
    logic [WORD_W-1:0]       req_off_q;
    logic [DATA_WIDTH-1:0]   req_wdata_q;
    logic                    refilled_q;
    logic                    line_hit;
    logic                    hit_c;
    logic                    miss_c;
    logic                    last_word;

    assign line_hit  = ln_valid && (ln_tag == req_tag_q);
    assign last_word = (word_cnt_q == LAST_WORD);

    // The compare that closes a refill is the tail of a miss, not a new hit.
    assign hit_c  = (state_q == ST_COMPARE) && line_hit && !refilled_q;
    assign miss_c = (state_q == ST_COMPARE) && !line_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            req_wr_q    <= 1'b0;
            req_tag_q   <= '0;
            req_set_q   <= '0;
            req_off_q   <= '0;
            req_wdata_q <= '0;
            refilled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= cnt_d;
            if (state_q == ST_IDLE && cpu_req) begin
                req_wr_q    <= cpu_wr;
                req_tag_q   <= cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                req_set_q   <= cpu_addr[OFFSET_WIDTH +: SET_WIDTH];
                req_off_q   <= cpu_addr[2 +: WORD_W];
                req_wdata_q <= cpu_wdata;
                refilled_q  <= 1'b0;
            end else if (state_q == ST_REFILL && state_d == ST_COMPARE) begin
                refilled_q  <= 1'b1;
            end
        end
    end

    // Next-state and bus outputs; everything idles at zero outside an active phase.
    always_comb begin
        state_d      = state_q;
        cnt_d        = word_cnt_q;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        ln_sel       = '0;
        ln_offset    = '0;
        ln_w_en      = 1'b0;
        ln_set_valid = 1'b0;
        ln_set_dirty = 1'b0;
        ln_set_tag   = '0;
        ln_wdata     = '0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) state_d = ST_COMPARE;
            end

            ST_COMPARE: begin
                ln_sel    = req_set_q;
                ln_offset = req_off_q;
                if (line_hit) begin
                    cpu_ready = 1'b1;
                    state_d   = ST_IDLE;
                    if (req_wr_q) begin
                        ln_w_en      = 1'b1;
                        ln_set_valid = 1'b1;
                        ln_set_dirty = 1'b1;
                        ln_set_tag   = ln_tag;
                        ln_wdata     = req_wdata_q;
                    end else begin
                        cpu_rdata = ln_rdata;
                    end
                end else if (ln_valid && ln_dirty) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_REFILL;
                end
            end

            ST_WRITEBACK: begin
                ln_sel    = req_set_q;
                ln_offset = word_cnt_q;
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {ln_tag, req_set_q, word_cnt_q, 2'b00};
                mem_wdata = ln_rdata;
                if (mem_ack) begin
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = ST_REFILL;
                    end else begin
                        cnt_d = word_cnt_q + WORD_W'(1);
                    end
                end
            end

            ST_REFILL: begin
                ln_sel    = req_set_q;
                ln_offset = word_cnt_q;
                mem_req   = 1'b1;
                mem_addr  = {req_tag_q, req_set_q, word_cnt_q, 2'b00};
                if (mem_ack) begin
                    // Line stays invalid until its final word lands.
                    ln_w_en      = 1'b1;
                    ln_set_valid = last_word;
                    ln_set_tag   = req_tag_q;
                    ln_wdata     = mem_rdata;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = ST_COMPARE;
                    end else begin
                        cnt_d = word_cnt_q + WORD_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    logic unused_addr;
    assign unused_addr = ^cpu_addr[1:0];

`ifdef CACHE_PERF_CNT_EN
    cache_perf_cnt u_perf_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .hit_inc  (hit_c),
        .miss_inc (miss_c),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;

    logic unused_perf;
    assign unused_perf = hit_c ^ miss_c;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: behavioural line store plus a memory responder with variable ack delay.
module tb_cache_ctrl;

`ifdef CACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        cpu_req   = 1'b0;
    logic        cpu_wr    = 1'b0;
    logic [31:0] cpu_addr  = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic [1:0]  ln_sel;
    logic [1:0]  ln_offset;
    logic        ln_w_en, ln_set_valid, ln_set_dirty;
    logic [25:0] ln_set_tag;
    logic [31:0] ln_wdata;
    logic        ln_valid, ln_dirty;
    logic [25:0] ln_tag;
    logic [31:0] ln_rdata;
    logic        mem_req, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack   = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] hit_cnt, miss_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .cpu_req      (cpu_req),
        .cpu_wr       (cpu_wr),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ready    (cpu_ready),
        .cpu_rdata    (cpu_rdata),
        .ln_sel       (ln_sel),
        .ln_offset    (ln_offset),
        .ln_w_en      (ln_w_en),
        .ln_set_valid (ln_set_valid),
        .ln_set_dirty (ln_set_dirty),
        .ln_set_tag   (ln_set_tag),
        .ln_wdata     (ln_wdata),
        .ln_valid     (ln_valid),
        .ln_dirty     (ln_dirty),
        .ln_tag       (ln_tag),
        .ln_rdata     (ln_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    // Line store: combinational read, write on the clock edge; not cleared by resetn.
    logic        lv [4]    = '{default: 1'b0};
    logic        ld [4]    = '{default: 1'b0};
    logic [25:0] lt [4]    = '{default: 26'd0};
    logic [31:0] lw [4][4] = '{default: '{default: 32'd0}};

    assign ln_valid = lv[ln_sel];
    assign ln_dirty = ld[ln_sel];
    assign ln_tag   = lt[ln_sel];
    assign ln_rdata = lw[ln_sel][ln_offset];

    always @(posedge clk) begin
        if (ln_w_en) begin
            lv[ln_sel]            <= ln_set_valid;
            ld[ln_sel]            <= ln_set_dirty;
            lt[ln_sel]            <= ln_set_tag;
            lw[ln_sel][ln_offset] <= ln_wdata;
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: acks after ack_delay held cycles, logs traffic, flags bus changes while waiting.
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic        unstable  = 1'b0;
    logic [64:0] snap      = '0;
    logic [31:0] wb_addr_q [$];
    logic [31:0] wb_data_q [$];
    logic [31:0] rf_addr_q [$];

    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (resetn && mem_req) begin
            if (wait_cnt == 0)
                snap = {mem_wr, mem_addr, mem_wdata};
            else if ({mem_wr, mem_addr, mem_wdata} !== snap)
                unstable = 1'b1;
            if (wait_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                if (mem_wr) begin
                    wb_addr_q.push_back(mem_addr);
                    wb_data_q.push_back(mem_wdata);
                end else begin
                    rf_addr_q.push_back(mem_addr);
                    mem_rdata = mem_word(mem_addr);
                end
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one CPU access; lat counts the request cycle as 1 and the ready cycle inclusive.
    task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic ready, output logic [31:0] rdata,
                              output int lat, output logic saw_mem);
        cpu_req   = 1'b1;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        ready     = 1'b0;
        rdata     = '0;
        saw_mem   = 1'b0;
        lat       = 1;
        while (!ready && lat < 400) begin
            @(negedge clk);
            lat++;
            if (mem_req) saw_mem = 1'b1;
            if (cpu_ready) begin
                ready = 1'b1;
                rdata = cpu_rdata;
            end
        end
        cpu_req   = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        @(negedge clk);
    endtask

    initial begin
        logic        rdy;
        logic [31:0] rd;
        int          lat;
        logic        saw;
        logic        found;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_ln_w_en",   32'(ln_w_en),   32'd0);
        check("rst_mem_addr",  mem_addr,       32'd0);
        check("rst_hit_cnt",   hit_cnt,        32'd0);
        check("rst_miss_cnt",  miss_cnt,       32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Cold load: clean miss, four-word refill
        rf_addr_q.delete();
        cpu_access(1'b0, 32'h0000_0010, 32'h0, rdy, rd, lat, saw);
        check("cold_ready",   32'(rdy), 32'd1);
        check("cold_rdata",   rd,       32'h5A5A_0010);
        check("cold_mem",     32'(saw), 32'd1);
        check("cold_wb_cnt",  32'(wb_addr_q.size()), 32'd0);
        check("cold_rf_cnt",  32'(rf_addr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("cold_rf_addr%0d", i), rf_addr_q[i], 32'h10 + 32'(4 * i));
        check("cold_miss_cnt", miss_cnt, PERF ? 32'd1 : 32'd0);
        check("cold_hit_cnt",  hit_cnt,  32'd0);

        // Repeat load: hit in 2 cycles, no memory traffic
        cpu_access(1'b0, 32'h0000_0014, 32'h0, rdy, rd, lat, saw);
        check("hit_ready",   32'(rdy), 32'd1);
        check("hit_latency", 32'(lat), 32'd2);
        check("hit_rdata",   rd,       32'h5A5A_0014);
        check("hit_mem",     32'(saw), 32'd0);
        check("hit_hit_cnt", hit_cnt,  PERF ? 32'd1 : 32'd0);

        // Store hit then load back
        cpu_access(1'b1, 32'h0000_0014, 32'hDEAD_BEEF, rdy, rd, lat, saw);
        check("st_ready",   32'(rdy), 32'd1);
        check("st_latency", 32'(lat), 32'd2);
        check("st_mem",     32'(saw), 32'd0);
        cpu_access(1'b0, 32'h0000_0014, 32'h0, rdy, rd, lat, saw);
        check("st_ld_rdata", rd,          32'hDEAD_BEEF);
        check("st_dirty",    32'(ld[1]),  32'd1);
        check("st_valid",    32'(lv[1]),  32'd1);
        check("st_hit_cnt",  hit_cnt,     PERF ? 32'd3 : 32'd0);

        // Conflict miss on a dirty line with slow memory
        wb_addr_q.delete();
        wb_data_q.delete();
        rf_addr_q.delete();
        ack_delay = 5;
        unstable  = 1'b0;
        cpu_access(1'b0, 32'h0000_0050, 32'h0, rdy, rd, lat, saw);
        check("ev_ready",  32'(rdy), 32'd1);
        check("ev_rdata",  rd,       32'h5A5A_0050);
        check("ev_wb_cnt", 32'(wb_addr_q.size()), 32'd4);
        check("ev_rf_cnt", 32'(rf_addr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ev_wb_addr%0d", i), wb_addr_q[i], 32'h10 + 32'(4 * i));
            check($sformatf("ev_rf_addr%0d", i), rf_addr_q[i], 32'h50 + 32'(4 * i));
        end
        check("ev_wb_data0", wb_data_q[0], 32'h5A5A_0010);
        check("ev_wb_data1", wb_data_q[1], 32'hDEAD_BEEF);
        check("ev_wb_data2", wb_data_q[2], 32'h5A5A_0018);
        check("ev_wb_data3", wb_data_q[3], 32'h5A5A_001C);
        check("ev_stable",   32'(unstable), 32'd0);
        check("ev_clean",    32'(ld[1]),    32'd0);
        check("ev_miss_cnt", miss_cnt, PERF ? 32'd2 : 32'd0);
        check("ev_hit_cnt",  hit_cnt,  PERF ? 32'd3 : 32'd0);

        // Reset asserted during refill word 2
        ack_delay = 3;
        cpu_req   = 1'b1;
        cpu_wr    = 1'b0;
        cpu_addr  = 32'h0000_0090;
        found     = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (mem_req && !mem_wr && mem_addr == 32'h0000_0098) found = 1'b1;
        end
        check("ab_reached", 32'(found), 32'd1);
        cpu_req  = 1'b0;
        cpu_addr = '0;
        resetn   = 1'b0;
        #1;
        check("ab_mem_req",   32'(mem_req),   32'd0);
        check("ab_mem_addr",  mem_addr,       32'd0);
        check("ab_ln_w_en",   32'(ln_w_en),   32'd0);
        check("ab_cpu_ready", 32'(cpu_ready), 32'd0);
        check("ab_hit_cnt",   hit_cnt,        32'd0);
        check("ab_miss_cnt",  miss_cnt,       32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("ab_mem_idle",  32'(mem_req), 32'd0);
        check("ab_line_inv",  32'(lv[1]),   32'd0);

        // Same address again must miss and refill
        ack_delay = 0;
        rf_addr_q.delete();
        cpu_access(1'b0, 32'h0000_0090, 32'h0, rdy, rd, lat, saw);
        check("re_ready",    32'(rdy), 32'd1);
        check("re_mem",      32'(saw), 32'd1);
        check("re_rdata",    rd,       32'h5A5A_0090);
        check("re_rf_cnt",   32'(rf_addr_q.size()), 32'd4);
        check("re_rf_addr0", rf_addr_q[0], 32'h0000_0090);
        check("re_miss_cnt", miss_cnt, PERF ? 32'd1 : 32'd0);
        check("re_hit_cnt",  hit_cnt,  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 26, meaning tag bits per address.
REQ-002 SHALL have parameter SET_WIDTH, default 2, meaning set-index bits (2^SET_WIDTH direct-mapped lines).
REQ-003 SHALL have parameter OFFSET_WIDTH, default 4, meaning byte-offset bits per line (2^(OFFSET_WIDTH-2) words); TAG_WIDTH+SET_WIDTH+OFFSET_WIDTH SHALL equal 32.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  clock, rising edge.
- resetn  in  1  async active-low reset.
- cpu_req  in  1  CPU access request, held until cpu_ready.
- cpu_wr  in  1  1=store, 0=load.
- cpu_addr  in  32  byte address, word aligned.
- cpu_wdata  in  32  store data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  load data, valid with cpu_ready.
- ln_sel  out  SET_WIDTH  selected line.
- ln_offset  out  OFFSET_WIDTH-2  word within line.
- ln_w_en, ln_set_valid, ln_set_dirty  out  1 each  line write strobe and next valid/dirty.
- ln_set_tag  out  TAG_WIDTH  tag written with ln_w_en.
- ln_wdata  out  32  word written.
- ln_valid, ln_dirty  in  1 each  selected line status.
- ln_tag  in  TAG_WIDTH  selected line tag.
- ln_rdata  in  32  selected word, combinational.
- mem_req  out  1  memory request, held until mem_ack.
- mem_wr  out  1  1=writeback word, 0=refill word.
- mem_addr  out  32  word address.
- mem_wdata  out  32  writeback data.
- mem_ack  in  1  one-cycle completion; mem_rdata valid with it.
- mem_rdata  in  32  refill data.
- hit_cnt, miss_cnt  out  32 each  performance counters.

Function
REQ-006 SHALL implement states IDLE, COMPARE, WRITEBACK, REFILL.
REQ-007 IDLE: on cpu_req SHALL latch cpu_wr/addr/wdata and go to COMPARE next cycle.
REQ-008 COMPARE: hit = ln_valid and ln_tag equals latched tag; load hit SHALL pulse cpu_ready with cpu_rdata=ln_rdata, return to IDLE; hit latency 2 cycles from accept.
REQ-009 Store hit SHALL assert ln_w_en with ln_set_valid=1, ln_set_dirty=1, ln_set_tag unchanged, ln_wdata=latched data, and pulse cpu_ready in the same cycle.
REQ-010 Miss with ln_valid and ln_dirty SHALL go to WRITEBACK; otherwise to REFILL.
REQ-011 WRITEBACK: word counter 0..N-1; mem_req=1, mem_wr=1, mem_addr={ln_tag,set,counter,2'b00}, mem_wdata=ln_rdata; counter SHALL advance only on mem_ack; ack on word N-1 SHALL clear counter and go to REFILL.
REQ-012 REFILL: mem_req=1, mem_wr=0, mem_addr={latched tag,set,counter,2'b00}; on each mem_ack SHALL write mem_rdata with ln_set_tag=new tag, ln_set_dirty=0, ln_set_valid=1 only on word N-1 (0 otherwise); then return to COMPARE, which hits.
REQ-013 mem_req, mem_wr, mem_addr, mem_wdata SHALL stay stable while mem_req=1 and no ack; mem_req SHALL drop the cycle after the final ack of a phase.
REQ-014 cpu_req input SHALL be ignored outside IDLE; cpu_ready SHALL never assert outside COMPARE.
REQ-015 ln_w_en SHALL be 0 in IDLE and WRITEBACK.

Reset
REQ-016 resetn=0 SHALL immediately force IDLE, counter 0, cpu_ready=0, mem_req=0, ln_w_en=0, all data outputs 0, hit_cnt=miss_cnt=0, including mid-WRITEBACK/REFILL; an aborted refill leaves ln_valid=0.

Configuration
REQ-017 With CACHE_PERF_CNT_EN defined, hit_cnt SHALL increment on each COMPARE hit and miss_cnt on each COMPARE miss, wrapping at 2^32; without it both SHALL be constant 0.

Structure
REQ-018 Package cache_pkg SHALL hold the state enum and default width constants.
REQ-019 Counters SHALL be sub-module cache_perf_cnt, instantiated only under CACHE_PERF_CNT_EN.

Verification
REQ-020 Cold load 0x0000_0010 -> REFILL of 4 words from 0x10..0x1C, then cpu_ready, cpu_rdata=word at 0x10; miss_cnt=1.
REQ-021 Repeat load 0x0000_0014 -> cpu_ready 2 cycles after accept, no mem_req; hit_cnt=1.
REQ-022 Store 0xDEADBEEF to 0x14 then load 0x14 -> rdata 0xDEADBEEF, ln_dirty=1.
REQ-023 Load 0x0000_0050 (same set, different tag, dirty) -> 4 writeback writes to 0x10..0x1C with 0xDEADBEEF at 0x14, then refill 0x50..0x5C.
REQ-024 mem_ack delayed 5 cycles per word -> mem_addr/mem_wdata stable throughout.
REQ-025 resetn low on refill word 2 -> mem_req=0 immediately, state IDLE; next load same address misses.
